crossbar_arbiter: RTL

Packet-level arbiter that sits directly upstream of the 2-port crossbar and drives its 2-bit `control_crossbar` select. It watches the head of the two input-port FIFOs and grants one packet at a time to the crossbar under a round-robin policy. While a grant is held it pops the source FIFO beat by beat, as destination ready allows. A watchdog releases a grant that stalls for too long.

---
 rtl/crossbar_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/crossbar_arbiter.sv
// Packet-level round-robin arbiter for a 2-port crossbar: grants one packet at a
// time, pops the source FIFO as destination ready allows, and releases stalled grants.
module crossbar_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid_0,
  input  logic       in_last_0,
  input  logic       in_valid_1,
  input  logic       in_last_1,
  input  logic       in_bcast_1,
  input  logic       out_ready_0,
  input  logic       out_ready_1,
  output logic [1:0] control_crossbar,
  output logic       pop_0,
  output logic       pop_1,
  output logic       out_valid_0,
  output logic       out_valid_1,
  output logic       timeout_err,
  output logic [1:0] o_dbg_state,
  output logic       o_dbg_rr
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);

  // State encoding doubles as the crossbar select, so the control output is registered for free.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_G0   = 2'b01,
    S_G1   = 2'b10,
    S_G1B  = 2'b11
  } state_t;

  state_t        r_state, w_next;
  logic          r_rr, w_rr_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          r_timeout, w_timeout_fire;
  logic          w_src_valid, w_src_last, w_dst_ready, w_pop;

  // Handshake: a beat transfers in any cycle where the source valid and the ready of
  // every targeted output are all high; pop and out_valid are combinational for that cycle.
  always_comb begin
    w_src_valid = 1'b0;
    w_src_last  = 1'b0;
    w_dst_ready = 1'b0;
    case (r_state)
      S_G0: begin
        w_src_valid = in_valid_0;
        w_src_last  = in_last_0;
        w_dst_ready = out_ready_1;
      end
      S_G1: begin
        w_src_valid = in_valid_1;
        w_src_last  = in_last_1;
        w_dst_ready = out_ready_0;
      end
      S_G1B: begin
        w_src_valid = in_valid_1;
        w_src_last  = in_last_1;
        w_dst_ready = out_ready_0 & out_ready_1;
      end
      default: ;
    endcase
    w_pop = w_src_valid & w_dst_ready;
  end

  assign pop_0       = (r_state == S_G0) & w_pop;
  assign pop_1       = ((r_state == S_G1) | (r_state == S_G1B)) & w_pop;
  assign out_valid_0 = ((r_state == S_G1) | (r_state == S_G1B)) & in_valid_1;
  assign out_valid_1 = ((r_state == S_G0) & in_valid_0) | ((r_state == S_G1B) & in_valid_1);

  always_comb begin
    w_next         = r_state;
    w_rr_next      = r_rr;
    w_cnt_next     = '0;
    w_timeout_fire = 1'b0;
    if (r_state == S_IDLE) begin
      if (in_valid_0 && (!in_valid_1 || !r_rr)) begin
        w_next = S_G0;
      end else if (in_valid_1) begin
        w_next = in_bcast_1 ? S_G1B : S_G1;
      end
    end else if (w_pop) begin
      if (w_src_last) begin
        w_next    = S_IDLE;
        w_rr_next = (r_state == S_G0);
      end
    end else if (r_cnt == LIM) begin
      // Stalled packet stays in its FIFO and competes again from IDLE.
      w_next         = S_IDLE;
      w_rr_next      = (r_state == S_G0);
      w_timeout_fire = 1'b1;
    end else begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rr      <= 1'b0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_rr      <= w_rr_next;
      r_cnt     <= w_cnt_next;
      r_timeout <= w_timeout_fire;
    end
  end

  assign control_crossbar = r_state;
  assign timeout_err      = r_timeout;
  assign o_dbg_state      = r_state;
  assign o_dbg_rr         = r_rr;

endmodule
